// File: rtl/fetch_control.sv
// Instruction-fetch sequencer: owns the program counter, strobes the MAR and
// holds the fetched byte in an instruction register until the decoder accepts it.
module fetch_control (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    output logic       mar_load,
    output logic [7:0] address,
    input  logic [7:0] instruction,
    output logic [7:0] ir,
    output logic       ir_valid,
    input  logic       ir_ready,
    input  logic       jump,
    input  logic [7:0] jump_addr,
    input  logic       halt,
    output logic [7:0] pc,
    output logic       halted
);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StHold,
        StHalted
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic       ir_valid_q, ir_valid_d;
    logic       mar_load_q, mar_load_d;
    logic       halted_q, halted_d;

    // mar_load is decided one cycle early so it is high exactly while in ISSUE.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        mar_load_d = 1'b0;
        halted_d   = halted_q;
        unique case (state_q)
            StIdle: begin
                if (jump) begin
                    pc_d = jump_addr;
                end
                if (enable) begin
                    state_d    = StIssue;
                    mar_load_d = 1'b1;
                end
            end
            StIssue: begin
                state_d = StWait;
            end
            StWait: begin
                ir_d       = instruction;
                ir_valid_d = 1'b1;
                pc_d       = pc_q + 8'd1;
                state_d    = StHold;
            end
            StHold: begin
                if (ir_ready) begin
                    ir_valid_d = 1'b0;
                    if (jump) begin
                        pc_d = jump_addr;
                    end
                    if (halt) begin
                        state_d  = StHalted;
                        halted_d = 1'b1;
                    end else if (enable) begin
                        state_d    = StIssue;
                        mar_load_d = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StHalted: begin
                state_d = StHalted;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            pc_q       <= 8'h00;
            ir_q       <= 8'h00;
            ir_valid_q <= 1'b0;
            mar_load_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            mar_load_q <= mar_load_d;
            halted_q   <= halted_d;
        end
    end

    assign address  = pc_q;
    assign pc       = pc_q;
    assign ir       = ir_q;
    assign ir_valid = ir_valid_q;
    assign mar_load = mar_load_q;
    assign halted   = halted_q;

endmodule

// File: tb/tb_fetch_control.sv
// Directed bench for fetch_control; memory returns 0xA0 + address.
module tb_fetch_control;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       mar_load;
    logic [7:0] address;
    logic [7:0] instruction;
    logic [7:0] ir;
    logic       ir_valid;
    logic       ir_ready;
    logic       jump;
    logic [7:0] jump_addr;
    logic       halt;
    logic [7:0] pc;
    logic       halted;

    int checks;
    int errors;

    fetch_control dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .mar_load   (mar_load),
        .address    (address),
        .instruction(instruction),
        .ir         (ir),
        .ir_valid   (ir_valid),
        .ir_ready   (ir_ready),
        .jump       (jump),
        .jump_addr  (jump_addr),
        .halt       (halt),
        .pc         (pc),
        .halted     (halted)
    );

    assign instruction = 8'hA0 + address;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; ir_ready = 1'b0;
        jump = 1'b0; jump_addr = 8'h00; halt = 1'b0;
        tick(); tick();
        checks++;
        if ({pc, address, ir, ir_valid, mar_load, halted} !== {8'h00, 8'h00, 8'h00, 3'b000}) begin
            errors++;
            $display("FAIL reset_values: got pc=%h addr=%h ir=%h v=%b ml=%b h=%b", pc, address,
                     ir, ir_valid, mar_load, halted);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({mar_load, ir_valid} !== 2'b00) begin
                errors++;
                $display("FAIL idle_no_fetch[%0d]: got ml=%b v=%b expected 0 0", i, mar_load,
                         ir_valid);
            end
        end
    endtask

    task automatic test_linear();
        enable = 1'b1; ir_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({mar_load, address} !== {1'b1, 8'(i)}) begin
                errors++;
                $display("FAIL linear_issue[%0d]: got ml=%b addr=%h expected 1 %h", i, mar_load,
                         address, 8'(i));
            end
            tick();
            checks++;
            if ({mar_load, ir_valid} !== 2'b00) begin
                errors++;
                $display("FAIL linear_wait[%0d]: got ml=%b v=%b expected 0 0", i, mar_load,
                         ir_valid);
            end
            tick();
            checks++;
            if ({ir_valid, ir, pc, mar_load} !== {1'b1, 8'hA0 + 8'(i), 8'(i + 1), 1'b0}) begin
                errors++;
                $display("FAIL linear_hold[%0d]: got v=%b ir=%h pc=%h ml=%b expected 1 %h %h 0",
                         i, ir_valid, ir, pc, mar_load, 8'hA0 + 8'(i), 8'(i + 1));
            end
        end
    endtask

    task automatic test_backpressure();
        ir_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({ir_valid, ir, mar_load} !== {1'b1, 8'hA2, 1'b0}) begin
                errors++;
                $display("FAIL backpressure[%0d]: got v=%b ir=%h ml=%b expected 1 a2 0", i,
                         ir_valid, ir, mar_load);
            end
        end
        ir_ready = 1'b1;
        tick();
        checks++;
        if ({mar_load, address, ir_valid} !== {1'b1, 8'h03, 1'b0}) begin
            errors++;
            $display("FAIL bp_release: got ml=%b addr=%h v=%b expected 1 03 0", mar_load,
                     address, ir_valid);
        end
        tick(); tick();
        checks++;
        if ({ir_valid, ir, pc} !== {1'b1, 8'hA3, 8'h04}) begin
            errors++;
            $display("FAIL bp_next_ir: got v=%b ir=%h pc=%h expected 1 a3 04", ir_valid, ir, pc);
        end
    endtask

    task automatic test_jump();
        jump = 1'b1; jump_addr = 8'h80;
        tick();
        jump = 1'b0;
        checks++;
        if ({mar_load, address} !== {1'b1, 8'h80}) begin
            errors++;
            $display("FAIL jump_issue: got ml=%b addr=%h expected 1 80", mar_load, address);
        end
        tick();
        jump = 1'b1; jump_addr = 8'h40;
        tick();
        jump = 1'b0;
        checks++;
        if ({pc, ir, ir_valid} !== {8'h81, 8'h20, 1'b1}) begin
            errors++;
            $display("FAIL jump_in_wait_ignored: got pc=%h ir=%h v=%b expected 81 20 1", pc, ir,
                     ir_valid);
        end
    endtask

    task automatic test_wrap();
        jump = 1'b1; jump_addr = 8'hFF;
        tick();
        jump = 1'b0;
        checks++;
        if ({mar_load, address} !== {1'b1, 8'hFF}) begin
            errors++;
            $display("FAIL wrap_issue_ff: got ml=%b addr=%h expected 1 ff", mar_load, address);
        end
        tick(); tick();
        checks++;
        if ({ir, pc, address} !== {8'h9F, 8'h00, 8'h00}) begin
            errors++;
            $display("FAIL wrap_pc: got ir=%h pc=%h addr=%h expected 9f 00 00", ir, pc, address);
        end
        tick();
        checks++;
        if ({mar_load, address} !== {1'b1, 8'h00}) begin
            errors++;
            $display("FAIL wrap_issue_00: got ml=%b addr=%h expected 1 00", mar_load, address);
        end
        tick(); tick();
        checks++;
        if ({ir, pc} !== {8'hA0, 8'h01}) begin
            errors++;
            $display("FAIL wrap_hold: got ir=%h pc=%h expected a0 01", ir, pc);
        end
    endtask

    task automatic test_halt();
        halt = 1'b1; jump = 1'b1; jump_addr = 8'h10;
        tick();
        halt = 1'b0; jump_addr = 8'h55;
        checks++;
        if ({halted, pc, ir_valid, mar_load} !== {1'b1, 8'h10, 2'b00}) begin
            errors++;
            $display("FAIL halt_enter: got h=%b pc=%h v=%b ml=%b expected 1 10 0 0", halted, pc,
                     ir_valid, mar_load);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if ({halted, pc, mar_load, ir_valid} !== {1'b1, 8'h10, 2'b00}) begin
                errors++;
                $display("FAIL halt_stay[%0d]: got h=%b pc=%h ml=%b v=%b expected 1 10 0 0", i,
                         halted, pc, mar_load, ir_valid);
            end
        end
        jump = 1'b0;
    endtask

    task automatic test_reset_mid();
        rst = 1'b1; enable = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({halted, mar_load, address} !== {1'b0, 1'b1, 8'h00}) begin
            errors++;
            $display("FAIL rst_from_halt: got h=%b ml=%b addr=%h expected 0 1 00", halted,
                     mar_load, address);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({mar_load, pc, ir_valid} !== {1'b0, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL rst_mid_issue: got ml=%b pc=%h v=%b expected 0 00 0", mar_load, pc,
                     ir_valid);
        end
        tick();
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({ir_valid, pc, ir, mar_load} !== {1'b0, 8'h00, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL rst_mid_wait: got v=%b pc=%h ir=%h ml=%b expected 0 00 00 0",
                     ir_valid, pc, ir, mar_load);
        end
        enable = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({mar_load, ir_valid, pc} !== {2'b00, 8'h00}) begin
                errors++;
                $display("FAIL rst_release_idle[%0d]: got ml=%b v=%b pc=%h expected 0 0 00", i,
                         mar_load, ir_valid, pc);
            end
        end
    endtask

    task automatic test_enable_drop();
        enable = 1'b1; ir_ready = 1'b1;
        tick();
        enable = 1'b0;
        tick(); tick();
        checks++;
        if ({ir_valid, ir, pc} !== {1'b1, 8'hA0, 8'h01}) begin
            errors++;
            $display("FAIL drop_completes: got v=%b ir=%h pc=%h expected 1 a0 01", ir_valid, ir,
                     pc);
        end
        tick(); tick();
        checks++;
        if ({mar_load, ir_valid, pc} !== {2'b00, 8'h01}) begin
            errors++;
            $display("FAIL drop_to_idle: got ml=%b v=%b pc=%h expected 0 0 01", mar_load,
                     ir_valid, pc);
        end
        jump = 1'b1; jump_addr = 8'h33;
        tick();
        jump = 1'b0;
        checks++;
        if ({pc, mar_load} !== {8'h33, 1'b0}) begin
            errors++;
            $display("FAIL idle_jump: got pc=%h ml=%b expected 33 0", pc, mar_load);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_linear();
        test_backpressure();
        test_jump();
        test_wrap();
        test_halt();
        test_reset_mid();
        test_enable_drop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
